// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit; optional divider via MULTDIV_DIV_EN.
// Latency: WIDTH edges from accept to the one-cycle result_ready pulse (undivided build: start_div completes next edge).
// Backpressure: busy stalls the issuer; starts seen while running are dropped, not queued.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             busy,
    output logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out,
    output logic             exception
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] iter_cnt;
    // Shared datapath: {acc_hi, acc_lo} is the Booth accumulator/multiplier pair or
    // the divider's partial remainder/quotient pair; opnd_m is multiplicand or divisor.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd_m;
    logic             booth_q;
    logic [TAG_W-1:0] tag_q;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     mul_hi;
    logic [WIDTH-1:0]   mul_lo;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             step_q;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;

    // Accumulator is one bit wider than WIDTH so adding a most-negative multiplicand cannot overflow.
    always_comb begin
        m_ext = {opnd_m[WIDTH-1], opnd_m};
        case ({acc_lo[0], booth_q})
            2'b01:   booth_sum = acc_hi + m_ext;
            2'b10:   booth_sum = acc_hi - m_ext;
            default: booth_sum = acc_hi;
        endcase
        mul_hi  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_lo  = {booth_sum[0], acc_lo[WIDTH-1:1]};
        product = {mul_hi[WIDTH-1:0], mul_lo};
    end

`ifdef MULTDIV_DIV_EN
    logic             op_div;
    logic             div_neg;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Magnitudes fit unsigned WIDTH bits, including the most-negative value.
    always_comb begin
        abs_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
        abs_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_m};
        div_hi    = div_trial[WIDTH] ? div_shift : div_trial;
        div_lo    = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
        div_quo   = div_neg ? -div_lo : div_lo;
    end
`endif

    always_comb begin
        step_hi    = mul_hi;
        step_lo    = mul_lo;
        step_q     = acc_lo[0];
        fin_result = product[WIDTH-1:0];
        fin_exc    = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};
`ifdef MULTDIV_DIV_EN
        if (op_div) begin
            step_hi    = div_hi;
            step_lo    = div_lo;
            step_q     = 1'b0;
            fin_result = div_zero ? '0 : div_quo;
            fin_exc    = div_zero | div_ovf;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            iter_cnt     <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opnd_m       <= '0;
            booth_q      <= 1'b0;
            tag_q        <= '0;
            busy         <= 1'b0;
            result_ready <= 1'b0;
            result       <= '0;
            tag_out      <= '0;
            exception    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            op_div       <= 1'b0;
            div_neg      <= 1'b0;
            div_zero     <= 1'b0;
            div_ovf      <= 1'b0;
`endif
        end else if (flush) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    iter_cnt <= iter_cnt + CNT_W'(1);
                    acc_hi   <= step_hi;
                    acc_lo   <= step_lo;
                    booth_q  <= step_q;
                    if (iter_cnt == LAST_ITER) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_ready <= 1'b1;
                        result       <= fin_result;
                        exception    <= fin_exc;
                        tag_out      <= tag_q;
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_ready <= 1'b0;
                    if (start_mult) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        iter_cnt <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= operand_b;
                        opnd_m   <= operand_a;
                        booth_q  <= 1'b0;
                        tag_q    <= tag_in;
`ifdef MULTDIV_DIV_EN
                        op_div   <= 1'b0;
`endif
                    end else if (start_div) begin
`ifdef MULTDIV_DIV_EN
                        state    <= RUN;
                        busy     <= 1'b1;
                        iter_cnt <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= abs_a;
                        opnd_m   <= abs_b;
                        booth_q  <= 1'b0;
                        tag_q    <= tag_in;
                        op_div   <= 1'b1;
                        div_neg  <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        div_zero <= operand_b == '0;
                        div_ovf  <= (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
`else
                        state        <= DONE;
                        result_ready <= 1'b1;
                        result       <= '0;
                        exception    <= 1'b1;
                        tag_out      <= tag_in;
`endif
                    end
                end
            endcase
        end
    end

endmodule
